// File: rtl/ecc16_err_monitor.sv
// ecc16_err_monitor: one-entry valid/ready output buffer for corrected SEC-DED words,
// plus saturating single/double error counters, sticky flags, a running word index
// and the index of the first uncorrectable word since reset or clear.
module ecc16_err_monitor #(
    parameter int CNT_W = 8,
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      dec_in,
    input  logic [1:0]       err_in,
    input  logic             ecc_en,
    input  logic             cnt_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [1:0]       out_err,
    output logic [CNT_W-1:0] sec_cnt,
    output logic [CNT_W-1:0] ded_cnt,
    output logic             sec_flag,
    output logic             ded_flag,
    output logic [IDX_W-1:0] first_ded_idx,
    output logic [IDX_W-1:0] word_idx
);

    // Add one unless the counter already sits at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        if (inc && (c != {CNT_W{1'b1}})) begin
            return c + CNT_W'(1);
        end
        return c;
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_data_q, out_data_d;
    logic [1:0]       out_err_q, out_err_d;
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0] ded_cnt_q, ded_cnt_d;
    logic             sec_flag_q, sec_flag_d;
    logic             ded_flag_q, ded_flag_d;
    logic [IDX_W-1:0] first_ded_idx_q, first_ded_idx_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;

    logic             accept;
    logic [1:0]       eff_err;
    logic             sec_inc;
    logic             ded_inc;
    logic [CNT_W-1:0] sec_base, ded_base;
    logic             sec_flag_base, ded_flag_base;
    logic [IDX_W-1:0] idx_base, first_base;

    // Handshake and event decode; errors only count on an accepted word with ECC enabled.
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        eff_err  = ecc_en ? err_in : 2'd0;
        sec_inc  = accept && eff_err[0];
        ded_inc  = accept && (eff_err == 2'd2);
    end

    // Next-state: clear is applied first so an event in the clear cycle still registers.
    always_comb begin
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        out_err_d       = out_err_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = dec_in;
            out_err_d   = eff_err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        sec_base      = cnt_clr ? '0 : sec_cnt_q;
        ded_base      = cnt_clr ? '0 : ded_cnt_q;
        sec_flag_base = cnt_clr ? 1'b0 : sec_flag_q;
        ded_flag_base = cnt_clr ? 1'b0 : ded_flag_q;
        idx_base      = cnt_clr ? '0 : word_idx_q;
        first_base    = cnt_clr ? '0 : first_ded_idx_q;

        sec_cnt_d       = sat_inc(sec_base, sec_inc);
        ded_cnt_d       = sat_inc(ded_base, ded_inc);
        sec_flag_d      = sec_flag_base | sec_inc;
        ded_flag_d      = ded_flag_base | ded_inc;
        word_idx_d      = idx_base + IDX_W'(accept);
        // First uncorrectable word records the index it arrived at, before its own increment.
        first_ded_idx_d = (ded_inc && !ded_flag_base) ? idx_base : first_base;
    end

    // State registers; async reset drops any buffered word and zeroes all accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_err_q       <= '0;
            sec_cnt_q       <= '0;
            ded_cnt_q       <= '0;
            sec_flag_q      <= 1'b0;
            ded_flag_q      <= 1'b0;
            first_ded_idx_q <= '0;
            word_idx_q      <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_err_q       <= out_err_d;
            sec_cnt_q       <= sec_cnt_d;
            ded_cnt_q       <= ded_cnt_d;
            sec_flag_q      <= sec_flag_d;
            ded_flag_q      <= ded_flag_d;
            first_ded_idx_q <= first_ded_idx_d;
            word_idx_q      <= word_idx_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_err       = out_err_q;
    assign sec_cnt       = sec_cnt_q;
    assign ded_cnt       = ded_cnt_q;
    assign sec_flag      = sec_flag_q;
    assign ded_flag      = ded_flag_q;
    assign first_ded_idx = first_ded_idx_q;
    assign word_idx      = word_idx_q;

endmodule

// File: tb/tb_ecc16_err_monitor.sv
// Testbench for ecc16_err_monitor: directed scenarios plus a randomized run,
// all checked against a behavioural model of the buffer and error accounting.
module tb_ecc16_err_monitor;

    localparam int CNT_W   = 8;
    localparam int IDX_W   = 12;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int IDX_MOD = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      dec_in;
    logic [1:0]       err_in;
    logic             ecc_en;
    logic             cnt_clr;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [1:0]       out_err;
    logic [CNT_W-1:0] sec_cnt;
    logic [CNT_W-1:0] ded_cnt;
    logic             sec_flag;
    logic             ded_flag;
    logic [IDX_W-1:0] first_ded_idx;
    logic [IDX_W-1:0] word_idx;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    bit          m_vld;
    logic [15:0] m_data;
    int          m_err;
    int          m_sec, m_ded, m_idx, m_first;
    bit          m_sflag, m_dflag;

    ecc16_err_monitor #(.CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dec_in(dec_in), .err_in(err_in), .ecc_en(ecc_en), .cnt_clr(cnt_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .sec_flag(sec_flag), .ded_flag(ded_flag),
        .first_ded_idx(first_ded_idx), .word_idx(word_idx)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_vld = 0; m_data = '0; m_err = 0;
        m_sec = 0; m_ded = 0; m_idx = 0; m_first = 0;
        m_sflag = 0; m_dflag = 0;
    endtask

    // One clock edge of the intended behaviour, computed from the pre-edge inputs.
    task automatic model_edge();
        bit acc;
        int e;
        acc = in_valid && (!m_vld || out_ready);
        e   = ecc_en ? int'(err_in) : 0;
        if (cnt_clr) begin
            m_sec = 0; m_ded = 0; m_sflag = 0; m_dflag = 0; m_first = 0; m_idx = 0;
        end
        if (acc) begin
            if (e == 1 || e == 3) begin
                m_sec   = (m_sec + 1 > CNT_MAX) ? CNT_MAX : m_sec + 1;
                m_sflag = 1;
            end
            if (e == 2) begin
                if (!m_dflag) m_first = m_idx;
                m_ded   = (m_ded + 1 > CNT_MAX) ? CNT_MAX : m_ded + 1;
                m_dflag = 1;
            end
            m_idx  = (m_idx + 1) % IDX_MOD;
            m_vld  = 1;
            m_data = dec_in;
            m_err  = e;
        end else if (out_ready) begin
            m_vld = 0;
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] e,
                         input logic en, input logic clr, input logic ordy);
        in_valid = v; dec_in = d; err_in = e; ecc_en = en; cnt_clr = clr; out_ready = ordy;
    endtask

    // Advance one clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 16'h0, 2'd0, 1, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, out_data, out_err, sec_cnt, ded_cnt, sec_flag, ded_flag, first_ded_idx, word_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b d=%h e=%0d sec=%0d ded=%0d sf=%0b df=%0b fi=%0d wi=%0d, want all 0",
                     out_valid, out_data, out_err, sec_cnt, ded_cnt, sec_flag, ded_flag, first_ded_idx, word_idx);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean();
        logic [15:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 16'($urandom);
            drive(1, d, 2'($urandom_range(0, 3)) & 2'b00, 1, 0, 1);
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== d || out_err !== 2'd0) begin
                n_fail++;
                $display("FAIL clean_word%0d: got v=%0b d=%h e=%0d want v=1 d=%h e=0", i, out_valid, out_data, out_err, d);
            end
        end
        drive(0, 16'h0, 2'd0, 1, 0, 1);
        step();
        n_tests++;
        if (out_valid !== 1'b0 || word_idx !== 12'd4 || sec_cnt !== 8'd0 || ded_cnt !== 8'd0 || sec_flag || ded_flag) begin
            n_fail++;
            $display("FAIL clean_counts: got v=%0b wi=%0d sec=%0d ded=%0d sf=%0b df=%0b want v=0 wi=4 counts/flags 0",
                     out_valid, word_idx, sec_cnt, ded_cnt, sec_flag, ded_flag);
        end
    endtask

    task automatic test_errors();
        logic [1:0] errs[6] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd2};
        logic [15:0] d;
        drive(0, 16'h0, 2'd0, 1, 1, 1);
        step();
        for (int i = 0; i < 6; i++) begin
            d = 16'($urandom);
            drive(1, d, errs[i], 1, 0, 1);
            step();
            n_tests++;
            if (out_data !== d || out_err !== errs[i]) begin
                n_fail++;
                $display("FAIL err_word%0d: got d=%h e=%0d want d=%h e=%0d", i, out_data, out_err, d, errs[i]);
            end
        end
        drive(0, 16'h0, 2'd0, 1, 0, 1);
        step();
        n_tests++;
        if (sec_cnt !== 8'd2 || ded_cnt !== 8'd2 || first_ded_idx !== 12'd3 || !sec_flag || !ded_flag || word_idx !== 12'd6) begin
            n_fail++;
            $display("FAIL err_summary: got sec=%0d ded=%0d fi=%0d sf=%0b df=%0b wi=%0d want 2 2 3 1 1 6",
                     sec_cnt, ded_cnt, first_ded_idx, sec_flag, ded_flag, word_idx);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a, b;
        a = 16'hA5A5; b = 16'h5A5A;
        drive(0, 16'h0, 2'd0, 1, 1, 1);
        step();
        drive(1, a, 2'd1, 1, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, b, 2'd1, 1, 0, 0);
            #1;
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_in_ready%0d: got %0b want 0", i, in_ready);
            end
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== a || word_idx !== 12'd1 || sec_cnt !== 8'd1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%0b d=%h wi=%0d sec=%0d want v=1 d=%h wi=1 sec=1", i, out_valid, out_data, word_idx, sec_cnt, a);
            end
        end
        drive(1, b, 2'd1, 1, 0, 1);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %0b want 1", in_ready);
        end
        step();
        drive(0, 16'h0, 2'd0, 1, 0, 1);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== b || word_idx !== 12'd2 || sec_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL bp_release: got v=%0b d=%h wi=%0d sec=%0d want v=1 d=%h wi=2 sec=2", out_valid, out_data, word_idx, sec_cnt, b);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0 || word_idx !== 12'd2 || sec_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL bp_once: got v=%0b wi=%0d sec=%0d want v=0 wi=2 sec=2", out_valid, word_idx, sec_cnt);
        end
    endtask

    task automatic test_saturation();
        drive(0, 16'h0, 2'd0, 1, 1, 1);
        step();
        for (int i = 0; i < 300; i++) begin
            drive(1, 16'($urandom), 2'd1, 1, 0, 1);
            step();
        end
        n_tests++;
        if (sec_cnt !== 8'd255 || word_idx !== 12'd300) begin
            n_fail++;
            $display("FAIL sat_sec: got sec=%0d wi=%0d want 255 300", sec_cnt, word_idx);
        end
        drive(1, 16'h1234, 2'd1, 1, 1, 1);
        step();
        n_tests++;
        if (sec_cnt !== 8'd1 || word_idx !== 12'd1 || sec_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_clr_event: got sec=%0d wi=%0d sf=%0b want 1 1 1", sec_cnt, word_idx, sec_flag);
        end
    endtask

    task automatic test_ecc_disable();
        logic [15:0] d;
        drive(0, 16'h0, 2'd0, 0, 1, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            d = 16'($urandom);
            drive(1, d, 2'd2, 0, 0, 1);
            step();
            n_tests++;
            if (out_data !== d || out_err !== 2'd0 || ded_cnt !== 8'd0 || ded_flag !== 1'b0) begin
                n_fail++;
                $display("FAIL ecc_off%0d: got d=%h e=%0d ded=%0d df=%0b want d=%h e=0 ded=0 df=0", i, out_data, out_err, ded_cnt, ded_flag, d);
            end
        end
        n_tests++;
        if (word_idx !== 12'd5 || first_ded_idx !== 12'd0) begin
            n_fail++;
            $display("FAIL ecc_off_idx: got wi=%0d fi=%0d want 5 0", word_idx, first_ded_idx);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom), 1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 2) != 0));
            #1;
            n_tests++;
            if (in_ready !== (!m_vld || out_ready)) begin
                n_fail++;
                $display("FAIL rand_in_ready@%0d: got %0b want %0b", i, in_ready, (!m_vld || out_ready));
            end
            step();
            n_tests++;
            if (out_valid !== m_vld || (m_vld && (out_data !== m_data || out_err !== 2'(m_err))) ||
                sec_cnt !== 8'(m_sec) || ded_cnt !== 8'(m_ded) || sec_flag !== m_sflag || ded_flag !== m_dflag ||
                first_ded_idx !== 12'(m_first) || word_idx !== 12'(m_idx)) begin
                n_fail++;
                $display("FAIL rand_state@%0d: got v=%0b d=%h e=%0d sec=%0d ded=%0d sf=%0b df=%0b fi=%0d wi=%0d want v=%0b d=%h e=%0d sec=%0d ded=%0d sf=%0b df=%0b fi=%0d wi=%0d",
                         i, out_valid, out_data, out_err, sec_cnt, ded_cnt, sec_flag, ded_flag, first_ded_idx, word_idx,
                         m_vld, m_data, m_err, m_sec, m_ded, m_sflag, m_dflag, m_first, m_idx);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(0, 16'h0, 2'd0, 1, 1, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 16'($urandom), 2'd2, 1, 0, 1);
            step();
        end
        drive(0, 16'h0, 2'd0, 1, 0, 0);
        step();
        n_tests++;
        if (out_valid !== 1'b1 || ded_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL areset_pre: got v=%0b ded=%0d want v=1 ded=5", out_valid, ded_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || ded_cnt !== 8'd0 || ded_flag !== 1'b0 || word_idx !== 12'd0) begin
            n_fail++;
            $display("FAIL areset_async: got v=%0b ded=%0d df=%0b wi=%0d want all 0", out_valid, ded_cnt, ded_flag, word_idx);
        end
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_release: got v=%0b rdy=%0b want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_errors();
        test_backpressure();
        test_saturation();
        test_ecc_disable();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
